// File: rtl/ohsm_monitor.sv
// Receive-side monitor for the one-hot phase sequencer: decodes the phase bus into an
// index and entry strobes, counts completed rounds and flags illegal codes and transitions.
module ohsm_monitor #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned ERR_W    = 4,
  parameter int unsigned IDLE_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       sglobal,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [2:0]       enter,
  output logic             round_done,
  output logic [CNT_W-1:0] round_cnt,
  output logic             idle,
  output logic             err_code,
  output logic             err_trans,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    PhS1 = 2'd0,
    PhS2 = 2'd1,
    PhS3 = 2'd2
  } ph_e;

  localparam logic [ERR_W-1:0] ErrMax  = '1;
  localparam logic [15:0]      IdleMax = 16'(IDLE_MAX);

  ph_e              last_q, last_d;
  logic             phase_valid_q, phase_valid_d;
  logic [2:0]       enter_q, enter_d;
  logic             round_done_q, round_done_d;
  logic [CNT_W-1:0] round_cnt_q, round_cnt_d;
  logic [15:0]      idle_cnt_q, idle_cnt_d;
  logic             idle_q, idle_d;
  logic             err_code_q, err_code_d;
  logic             err_trans_q, err_trans_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  ph_e              new_ph;
  logic             code_ok;
  logic             trans_ok;
  logic             trans_good;
  logic             any_err;
  logic [ERR_W-1:0] err_base;

  always_comb begin
    code_ok = 1'b1;
    new_ph  = PhS1;
    case (sglobal)
      4'b0001: new_ph = PhS1;
      4'b0010: new_ph = PhS2;
      4'b0100: new_ph = PhS3;
      default: code_ok = 1'b0;
    endcase

    trans_ok = 1'b0;
    case (last_q)
      PhS1:    trans_ok = (new_ph == PhS1) || (new_ph == PhS2);
      PhS2:    trans_ok = (new_ph == PhS3);
      PhS3:    trans_ok = (new_ph == PhS1);
      default: trans_ok = 1'b0;
    endcase

    trans_good = code_ok && trans_ok;
    any_err    = !code_ok || !trans_ok;

    // An illegal transition still resynchronises to the new phase.
    last_d        = code_ok ? new_ph : last_q;
    phase_valid_d = code_ok;

    enter_d = 3'b000;
    if (trans_good && (new_ph != last_q)) begin
      enter_d[new_ph] = 1'b1;
    end

    round_done_d = trans_good && (last_q == PhS3) && (new_ph == PhS1);
    round_cnt_d  = round_done_d ? round_cnt_q + CNT_W'(1) : round_cnt_q;

    idle_cnt_d = 16'd0;
    if (trans_good && (last_q == PhS1) && (new_ph == PhS1)) begin
      idle_cnt_d = (idle_cnt_q < IdleMax) ? idle_cnt_q + 16'd1 : idle_cnt_q;
    end
    idle_d = (idle_cnt_d >= IdleMax);

    // Clear takes effect before the current cycle's error is recorded.
    err_base    = clr_err ? '0 : err_cnt_q;
    err_code_d  = (err_code_q && !clr_err) || !code_ok;
    err_trans_d = (err_trans_q && !clr_err) || (code_ok && !trans_ok);
    err_cnt_d   = (any_err && (err_base != ErrMax)) ? err_base + ERR_W'(1) : err_base;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q        <= PhS1;
      phase_valid_q <= 1'b0;
      enter_q       <= 3'b000;
      round_done_q  <= 1'b0;
      round_cnt_q   <= '0;
      idle_cnt_q    <= 16'd0;
      idle_q        <= 1'b0;
      err_code_q    <= 1'b0;
      err_trans_q   <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      last_q        <= last_d;
      phase_valid_q <= phase_valid_d;
      enter_q       <= enter_d;
      round_done_q  <= round_done_d;
      round_cnt_q   <= round_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      idle_q        <= idle_d;
      err_code_q    <= err_code_d;
      err_trans_q   <= err_trans_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign phase       = last_q;
  assign phase_valid = phase_valid_q;
  assign enter       = enter_q;
  assign round_done  = round_done_q;
  assign round_cnt   = round_cnt_q;
  assign idle        = idle_q;
  assign err_code    = err_code_q;
  assign err_trans   = err_trans_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ohsm_monitor.sv
// Directed bench for ohsm_monitor: a default instance and a narrow-counter instance
// (CNT_W=2, ERR_W=2) share the same stimulus.
module tb_ohsm_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sglobal;
  logic       clr_err;

  logic [1:0] a_phase, b_phase;
  logic       a_pv, b_pv;
  logic [2:0] a_enter, b_enter;
  logic       a_rd, b_rd;
  logic [7:0] a_rc;
  logic [1:0] b_rc;
  logic       a_idle, b_idle;
  logic       a_ec, b_ec;
  logic       a_et, b_et;
  logic [3:0] a_errc;
  logic [1:0] b_errc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ohsm_monitor dut_a (
    .clk        (clk),
    .reset      (reset),
    .sglobal    (sglobal),
    .clr_err    (clr_err),
    .phase      (a_phase),
    .phase_valid(a_pv),
    .enter      (a_enter),
    .round_done (a_rd),
    .round_cnt  (a_rc),
    .idle       (a_idle),
    .err_code   (a_ec),
    .err_trans  (a_et),
    .err_cnt    (a_errc)
  );

  ohsm_monitor #(
    .CNT_W   (2),
    .ERR_W   (2),
    .IDLE_MAX(16)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .sglobal    (sglobal),
    .clr_err    (clr_err),
    .phase      (b_phase),
    .phase_valid(b_pv),
    .enter      (b_enter),
    .round_done (b_rd),
    .round_cnt  (b_rc),
    .idle       (b_idle),
    .err_code   (b_ec),
    .err_trans  (b_et),
    .err_cnt    (b_errc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one sample, then look at the registered result 1ns after the edge.
  task automatic step(input logic [3:0] code, input logic clr, input logic rst);
    sglobal = code;
    clr_err = clr;
    reset   = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ph, input logic pv,
                         input logic [2:0] en, input logic rd, input logic idl,
                         input logic ec, input logic et, input logic [7:0] rca,
                         input logic [3:0] eca, input logic [1:0] rcb,
                         input logic [1:0] ecb);
    chk({tag, ".phase"}, a_phase, ph);
    chk({tag, ".pv"}, a_pv, pv);
    chk({tag, ".enter"}, a_enter, en);
    chk({tag, ".rd"}, a_rd, rd);
    chk({tag, ".idle"}, a_idle, idl);
    chk({tag, ".err_code"}, a_ec, ec);
    chk({tag, ".err_trans"}, a_et, et);
    chk({tag, ".rc_a"}, a_rc, rca);
    chk({tag, ".errc_a"}, a_errc, eca);
    chk({tag, ".rc_b"}, b_rc, rcb);
    chk({tag, ".errc_b"}, b_errc, ecb);
    chk({tag, ".enter_b"}, b_enter, en);
    chk({tag, ".pv_b"}, b_pv, pv);
  endtask

  initial begin
    sglobal = 4'b0001;
    clr_err = 1'b0;
    reset   = 1'b1;

    // Reset state
    step(4'b0001, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b1);
    chk_all("reset", 2'd0, 0, 3'b000, 0, 0, 0, 0, 8'd0, 4'd0, 2'd0, 2'd0);

    // Hold S1: idle rises on the 16th S1 sample
    for (int k = 1; k <= 20; k++) begin
      step(4'b0001, 1'b0, 1'b0);
      chk_all($sformatf("hold%0d", k), 2'd0, 1, 3'b000, 0, (k >= 16), 0, 0,
              8'd0, 4'd0, 2'd0, 2'd0);
    end

    // Three full rounds
    for (int r = 1; r <= 3; r++) begin
      step(4'b0010, 1'b0, 1'b0);
      chk_all($sformatf("r%0d.s2", r), 2'd1, 1, 3'b010, 0, 0, 0, 0,
              8'(r - 1), 4'd0, 2'(r - 1), 2'd0);
      step(4'b0100, 1'b0, 1'b0);
      chk_all($sformatf("r%0d.s3", r), 2'd2, 1, 3'b100, 0, 0, 0, 0,
              8'(r - 1), 4'd0, 2'(r - 1), 2'd0);
      step(4'b0001, 1'b0, 1'b0);
      chk_all($sformatf("r%0d.s1", r), 2'd0, 1, 3'b001, 1, 0, 0, 0,
              8'(r), 4'd0, 2'(r), 2'd0);
    end

    // Reset, then five rounds: narrow counter goes 1,2,3,0,1
    step(4'b0001, 1'b0, 1'b1);
    chk_all("reset2", 2'd0, 0, 3'b000, 0, 0, 0, 0, 8'd0, 4'd0, 2'd0, 2'd0);
    for (int r = 1; r <= 5; r++) begin
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0100, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b0);
      chk_all($sformatf("w%0d", r), 2'd0, 1, 3'b001, 1, 0, 0, 0,
              8'(r), 4'd0, 2'(r % 4), 2'd0);
    end

    // Illegal codes from S1, then legal S1->S2
    step(4'b1000, 1'b0, 1'b0);
    chk_all("ill_s4", 2'd0, 0, 3'b000, 0, 0, 1, 0, 8'd5, 4'd1, 2'd1, 2'd1);
    step(4'b0110, 1'b0, 1'b0);
    chk_all("ill_mh", 2'd0, 0, 3'b000, 0, 0, 1, 0, 8'd5, 4'd2, 2'd1, 2'd2);
    step(4'b0010, 1'b0, 1'b0);
    chk_all("resume", 2'd1, 1, 3'b010, 0, 0, 1, 0, 8'd5, 4'd2, 2'd1, 2'd2);

    // Clear on a legal cycle, walk back to S2
    step(4'b0100, 1'b1, 1'b0);
    chk_all("clr", 2'd2, 1, 3'b100, 0, 0, 0, 0, 8'd5, 4'd0, 2'd1, 2'd0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    chk_all("to_s2", 2'd1, 1, 3'b010, 0, 0, 0, 0, 8'd6, 4'd0, 2'd2, 2'd0);

    // Illegal S2->S1 transition resyncs without a round
    step(4'b0001, 1'b0, 1'b0);
    chk_all("bad_tr", 2'd0, 1, 3'b000, 0, 0, 0, 1, 8'd6, 4'd1, 2'd2, 2'd1);
    step(4'b0010, 1'b0, 1'b0);
    chk_all("after_tr", 2'd1, 1, 3'b010, 0, 0, 0, 1, 8'd6, 4'd1, 2'd2, 2'd1);

    // Five illegal cycles: narrow err_cnt saturates at 3
    for (int k = 1; k <= 5; k++) begin
      step(4'b0000, 1'b0, 1'b0);
      chk_all($sformatf("sat%0d", k), 2'd1, 0, 3'b000, 0, 0, 1, 1,
              8'd6, 4'(1 + k), 2'd2, ((1 + k) > 3) ? 2'd3 : 2'(1 + k));
    end

    // Clear together with an illegal code
    step(4'b1111, 1'b1, 1'b0);
    chk_all("clr_err", 2'd1, 0, 3'b000, 0, 0, 1, 0, 8'd6, 4'd1, 2'd2, 2'd1);

    // Enter S3, reset mid-round, restart with S1->S2
    step(4'b0100, 1'b0, 1'b0);
    chk_all("s3", 2'd2, 1, 3'b100, 0, 0, 1, 0, 8'd6, 4'd1, 2'd2, 2'd1);
    step(4'b0100, 1'b1, 1'b1);
    chk_all("rst_mid", 2'd0, 0, 3'b000, 0, 0, 0, 0, 8'd0, 4'd0, 2'd0, 2'd0);
    step(4'b0010, 1'b0, 1'b0);
    chk_all("post_rst", 2'd1, 1, 3'b010, 0, 0, 0, 0, 8'd0, 4'd0, 2'd0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
